// File: rtl/constants.sv
// Shared types and defaults for the RAM arbiter: FSM state encoding,
// the return-path tag carried alongside each RAM read, and default sizing.
package constants;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_RAM_LAT    = 2;

  // Wide enough for any sensible line size; the arbiter uses the low bits.
  localparam int TAG_IDX_W      = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_ISSUE = 3'd1,
    I_DRAIN = 3'd2,
    D_READ  = 3'd3,
    D_WRITE = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_i;
    logic [TAG_IDX_W-1:0] idx;
    logic                 last;
  } arb_tag_t;

  localparam arb_tag_t TAG_NONE = '0;

endpackage

// File: rtl/ram_lat_pipe.sv
// Delay line that carries a return tag for every RAM read so it lines up
// with ram_rdata exactly DEPTH cycles after the issue.
module ram_lat_pipe
  import constants::*;
#(
  parameter int DEPTH = DEF_RAM_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  arb_tag_t stage [DEPTH];

  // Shift tags one stage per cycle; reset drops anything still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage[k] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the instruction refill side and the
// data load/store side. Round-robin grant in IDLE, critical-word-first
// refill bursts, and return routing driven purely by the tag delay line.
module ram_arbiter
  import constants::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int RAM_LAT    = DEF_RAM_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_miss,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic [DATA_W-1:0]             i_word,
  output logic                          i_word_ready,
  output logic [$clog2(LINE_WORDS)-1:0] i_word_idx,
  output logic                          i_last,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  input  logic [DATA_W/8-1:0]           d_be,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_ack,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [DATA_W/8-1:0]           ram_be,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF   = $clog2(BE_W);
  localparam int CNT_W = $clog2(LINE_WORDS + RAM_LAT) + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * BE_W - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_i;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic              wr_ack;

  logic              i_act;
  logic              d_act;
  logic              grant_i;
  logic              grant_d;
  logic              issue_i;
  logic              issue_dr;
  logic              issue_dw;
  logic [IDX_W-1:0]  cur_idx;
  logic              d_rd_ack;

  arb_tag_t          tag_in;
  arb_tag_t          tag_out;

  // A requester whose completion strobe is showing this cycle is masked so
  // its still-high level request is not granted a second time.
  assign i_act   = i_miss & ~i_last;
  assign d_act   = d_req & ~d_ack;
  assign grant_i = (state == IDLE) & i_act & (~d_act | ~last_i);
  assign grant_d = (state == IDLE) & d_act & (~i_act | last_i);

  // Next-state selection; D_READ and I_DRAIN are timed by cnt so IDLE is
  // reached in the very cycle the final word comes back.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = I_ISSUE;
        end else if (grant_d) begin
          state_nxt = d_we ? D_WRITE : D_READ;
        end
      end
      I_ISSUE: begin
        if (cnt == CNT_W'(LINE_WORDS - 1)) begin
          state_nxt = (RAM_LAT == 1) ? IDLE : I_DRAIN;
        end
      end
      I_DRAIN: begin
        if (cnt == CNT_W'(RAM_LAT - 2)) begin
          state_nxt = IDLE;
        end
      end
      D_READ: begin
        if (cnt == CNT_W'(RAM_LAT - 1)) begin
          state_nxt = IDLE;
        end
      end
      D_WRITE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and per-state cycle counter, restarting on every change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Capture the winner's request at grant so a requester that drops or
  // changes its inputs mid-operation cannot corrupt the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_i    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (grant_i) begin
      last_i    <= 1'b1;
      lat_addr  <= i_addr;
    end else if (grant_d) begin
      last_i    <= 1'b0;
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_be    <= d_be;
    end
  end

  // Stores complete one cycle after their issue, independent of RAM_LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= (state == D_WRITE);
    end
  end

  assign issue_i  = (state == I_ISSUE);
  assign issue_dr = (state == D_READ) && (cnt == '0);
  assign issue_dw = (state == D_WRITE);

  // Critical word first: the index wraps inside the line.
  assign cur_idx = lat_addr[OFF +: IDX_W] + cnt[IDX_W-1:0];

  // RAM bus drive; everything is held at zero outside an issue cycle.
  always_comb begin
    ram_en    = issue_i | issue_dr | issue_dw;
    ram_we    = issue_dw;
    ram_be    = '0;
    ram_wdata = '0;
    ram_addr  = '0;
    if (issue_i) begin
      ram_addr = (lat_addr & ~LINE_MASK) | (ADDR_W'(cur_idx) << OFF);
    end else if (issue_dr) begin
      ram_addr = lat_addr;
    end else if (issue_dw) begin
      ram_addr  = lat_addr;
      ram_be    = lat_be;
      ram_wdata = lat_wdata;
    end
  end

  // Build the return tag for each read so routing never looks at state.
  always_comb begin
    tag_in = TAG_NONE;
    if (issue_i) begin
      tag_in.valid = 1'b1;
      tag_in.is_i  = 1'b1;
      tag_in.idx   = TAG_IDX_W'(cur_idx);
      tag_in.last  = (cnt == CNT_W'(LINE_WORDS - 1));
    end else if (issue_dr) begin
      tag_in.valid = 1'b1;
      tag_in.is_i  = 1'b0;
      tag_in.last  = 1'b1;
    end
  end

  ram_lat_pipe #(
    .DEPTH (RAM_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign i_word_ready = tag_out.valid & tag_out.is_i;
  assign i_last       = i_word_ready & tag_out.last;
  assign i_word_idx   = i_word_ready ? tag_out.idx[IDX_W-1:0] : '0;
  assign i_word       = i_word_ready ? ram_rdata : '0;

  assign d_rd_ack = tag_out.valid & ~tag_out.is_i;
  assign d_ack    = d_rd_ack | wr_ack;
  assign d_rdata  = d_rd_ack ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a fake RAM environment plus a transaction-level
// model that turns each grant into a cycle-indexed schedule of expected
// RAM bus activity and return strobes.
module tb_ram_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int RAM_LAT    = 2;
  localparam int NCYC       = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [31:0] i_addr;
  logic [31:0] i_word;
  logic        i_word_ready;
  logic [1:0]  i_word_idx;
  logic        i_last;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  ram_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .RAM_LAT    (RAM_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_miss       (i_miss),
    .i_addr       (i_addr),
    .i_word       (i_word),
    .i_word_ready (i_word_ready),
    .i_word_idx   (i_word_idx),
    .i_last       (i_last),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_be         (d_be),
    .d_rdata      (d_rdata),
    .d_ack        (d_ack),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  logic [31:0] env_mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] ram_ret [NCYC];

  logic [69:0] exp_ram [NCYC];
  logic [32:0] exp_d   [NCYC];
  logic [35:0] exp_i   [NCYC];

  int          free_at;
  bit          last_was_i;
  bit          i_granted;
  bit          d_granted;
  int          i_done_at;
  int          d_done_at;

  // Cycle counter and the RAM's read-return path, RAM_LAT cycles after issue.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_rdata <= (cyc + 1 >= RAM_LAT) ? ram_ret[cyc + 1 - RAM_LAT] : 32'h0;
  end

  task automatic checkOutput(input int c, input string tag);
    logic [69:0] ram_vec;
    logic [32:0] d_vec;
    logic [35:0] i_vec;
    ram_vec = {ram_en, ram_we, ram_be, ram_addr, ram_wdata};
    d_vec   = {d_ack, d_rdata};
    i_vec   = {i_word_ready, i_last, i_word_idx, i_word};
    checks++;
    assert (ram_vec === exp_ram[c]) else begin
      fails++;
      $error("FAIL %s_ram cyc=%0d got=%h want=%h", tag, c, ram_vec, exp_ram[c]);
    end
    checks++;
    assert (d_vec === exp_d[c]) else begin
      fails++;
      $error("FAIL %s_d cyc=%0d got=%h want=%h", tag, c, d_vec, exp_d[c]);
    end
    checks++;
    assert (i_vec === exp_i[c]) else begin
      fails++;
      $error("FAIL %s_i cyc=%0d got=%h want=%h", tag, c, i_vec, exp_i[c]);
    end
  endtask

  // The RAM itself: applies stores and records what a read returns.
  task automatic logRam(input int c);
    if (ram_en && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) env_mem[ram_addr[11:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end
      ram_ret[c] = 32'hBAD0_0000 ^ 32'(c);
    end else if (ram_en) begin
      ram_ret[c] = env_mem[ram_addr[11:2]];
    end else begin
      ram_ret[c] = 32'h5A5A_0000 ^ 32'(c);
    end
  endtask

  // Requesters let go of their level request the cycle after completion.
  task automatic tick(input string tag);
    @(negedge clk);
    checkOutput(cyc, tag);
    logRam(cyc);
    if (i_granted && cyc > i_done_at) begin
      i_miss = 1'b0;
      i_granted = 1'b0;
    end
    if (d_granted && cyc > d_done_at) begin
      d_req = 1'b0;
      d_granted = 1'b0;
    end
  endtask

  task automatic grantI(input int c);
    logic [31:0] base, addr;
    int w, idx;
    w    = int'((i_addr >> 2) % LINE_WORDS);
    base = i_addr & ~32'(LINE_WORDS * 4 - 1);
    for (int k = 0; k < LINE_WORDS; k++) begin
      idx  = (w + k) % LINE_WORDS;
      addr = base + 32'(idx * 4);
      exp_ram[c + 1 + k] = {1'b1, 1'b0, 4'b0, addr, 32'b0};
      exp_i[c + 1 + k + RAM_LAT] = {1'b1, (k == LINE_WORDS - 1), 2'(idx), ref_mem[addr[11:2]]};
    end
    free_at    = c + LINE_WORDS + RAM_LAT;
    i_done_at  = free_at;
    i_granted  = 1'b1;
    last_was_i = 1'b1;
  endtask

  task automatic grantD(input int c);
    if (d_we) begin
      exp_ram[c + 1] = {1'b1, 1'b1, d_be, d_addr, d_wdata};
      exp_d[c + 2]   = {1'b1, 32'b0};
      for (int b = 0; b < 4; b++) begin
        if (d_be[b]) ref_mem[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
      free_at = c + 2;
    end else begin
      exp_ram[c + 1]           = {1'b1, 1'b0, 4'b0, d_addr, 32'b0};
      exp_d[c + 1 + RAM_LAT]   = {1'b1, ref_mem[d_addr[11:2]]};
      free_at = c + 1 + RAM_LAT;
    end
    d_done_at  = free_at;
    d_granted  = 1'b1;
    last_was_i = 1'b0;
  endtask

  // Arbitration as seen from outside: once the previous operation has
  // delivered its final strobe, pick among requests not just completed,
  // alternating on a tie.
  task automatic applyStimulus();
    bit ia, da;
    int c;
    c = cyc;
    if (rst || c < free_at) return;
    ia = i_miss && !i_granted;
    da = d_req && !d_granted;
    if (ia && da) begin
      if (last_was_i) grantD(c);
      else grantI(c);
    end else if (ia) begin
      grantI(c);
    end else if (da) begin
      grantD(c);
    end
  endtask

  task automatic raiseI(input logic [31:0] a);
    i_miss = 1'b1;
    i_addr = a;
  endtask

  task automatic raiseD(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60; n++) begin
      tick(tag);
      applyStimulus();
      if (!i_miss && !d_req && !i_granted && !d_granted && cyc > free_at) break;
    end
  endtask

  initial begin
    rst        = 1'b1;
    i_miss     = 1'b0;
    i_addr     = 32'h0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = 32'h0;
    d_wdata    = 32'h0;
    d_be       = 4'h0;
    ram_rdata  = 32'h0;
    free_at    = 0;
    last_was_i = 1'b0;
    i_granted  = 1'b0;
    d_granted  = 1'b0;
    i_done_at  = 0;
    d_done_at  = 0;
    for (int i = 0; i < NCYC; i++) begin
      exp_ram[i] = '0;
      exp_d[i]   = '0;
      exp_i[i]   = '0;
      ram_ret[i] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;

    $display("[TB] reset");
    tick("reset");
    tick("reset");
    rst = 1'b0;
    applyStimulus();
    tick("idle");
    applyStimulus();

    $display("[TB] contention after reset");
    tick("cont1");
    raiseI(32'h1F4);
    raiseD(1'b0, 32'h44, 32'h0, 4'h0);
    applyStimulus();
    drain("cont1");

    $display("[TB] load");
    tick("load");
    raiseD(1'b0, 32'h40, 32'h0, 4'h0);
    applyStimulus();
    drain("load");

    $display("[TB] refill wrap");
    tick("refill");
    raiseI(32'h108);
    applyStimulus();
    drain("refill");

    $display("[TB] store");
    tick("store");
    raiseD(1'b1, 32'h20, 32'hCAFE_1234, 4'b0011);
    applyStimulus();
    drain("store");
    tick("st_rd");
    raiseD(1'b0, 32'h20, 32'h0, 4'h0);
    applyStimulus();
    drain("st_rd");

    $display("[TB] contention with D favoured");
    tick("cont2");
    raiseI(32'h200);
    applyStimulus();
    drain("cont2");
    tick("cont2");
    raiseI(32'h33C);
    raiseD(1'b0, 32'h80, 32'h0, 4'h0);
    applyStimulus();
    drain("cont2");

    $display("[TB] reset mid-burst");
    tick("rstmid");
    raiseI(32'h30C);
    applyStimulus();
    for (int n = 0; n < 2; n++) begin
      tick("rstmid");
      applyStimulus();
    end
    tick("rstmid");
    rst = 1'b1;
    i_miss = 1'b0;
    #1;
    checks++;
    assert ({ram_en, ram_we, ram_be, ram_addr, ram_wdata, d_ack, d_rdata, i_word_ready, i_last, i_word_idx, i_word} === 139'b0) else begin
      fails++;
      $error("FAIL rst_zero got=%h want=0", {ram_en, ram_we, ram_be, ram_addr, ram_wdata, d_ack, d_rdata, i_word_ready, i_last, i_word_idx, i_word});
    end
    for (int i = cyc + 1; i < NCYC; i++) begin
      exp_ram[i] = '0;
      exp_d[i]   = '0;
      exp_i[i]   = '0;
    end
    free_at    = 0;
    last_was_i = 1'b0;
    i_granted  = 1'b0;
    d_granted  = 1'b0;
    tick("rsthold");
    tick("rsthold");
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick("postrst");
      applyStimulus();
    end
    tick("fresh");
    raiseI(32'h104);
    applyStimulus();
    drain("fresh");

    $display("[TB] random traffic");
    while (cyc < NCYC - 40) begin
      tick("rand");
      if (i_granted && i_miss && $urandom_range(0, 9) == 0) begin
        i_miss = 1'b0;
        i_addr = $urandom;
      end
      if (d_granted && d_req && $urandom_range(0, 9) == 0) begin
        d_req  = 1'b0;
        d_addr = $urandom;
      end
      if (!i_miss && !i_granted && $urandom_range(0, 3) == 0) begin
        raiseI({20'h0, 10'($urandom_range(0, 1023)), 2'b00});
      end
      if (!d_req && !d_granted && $urandom_range(0, 2) == 0) begin
        raiseD(1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      end
      applyStimulus();
    end
    drain("tail");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the core's single-port RAM between two requesters. The instruction side issues cache-line refills on a fetch miss. The data side issues single-word loads and stores from the memory stage. The block sits between the core and the RAM, grants one requester at a time with round-robin fairness, and issues pipelined RAM reads. Returned words are routed back to the requester with exact fixed-latency timing.

## Interface
- ADDR_W, 32: byte-address width (matches `pc_size`).
- DATA_W, 32: word width (matches `memory_word`); byte lanes = DATA_W/8.
- LINE_WORDS, 4: words per I-side refill, power of two, ≥2.
- RAM_LAT, 2: cycles from `ram_en` (read) to valid `ram_rdata`, ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_miss  in  1  instruction refill request, level, held until `i_last`.
- i_addr  in  ADDR_W  miss address (critical word), stable while `i_miss`.
- i_word  out  DATA_W  refill word.
- i_word_ready  out  1  `i_word` valid this cycle.
- i_word_idx  out  log2(LINE_WORDS)  word index of `i_word` inside the line.
- i_last  out  1  final word of the burst.
- d_req  in  1  data request, level, held until `d_ack`.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  word-aligned byte address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data, valid with `d_ack` on loads.
- d_ack  out  1  single-cycle completion strobe.
- ram_en, ram_we  out  1  RAM access and write strobes.
- ram_be  out  DATA_W/8  RAM byte enables.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

## Operation
- FSM states: IDLE, I_ISSUE, I_DRAIN, D_READ, D_WRITE.
- IDLE arbitration, evaluated on the registered state:
  - Only one requester active: grant it.
  - Both active: grant the one not served last. The pointer resets to favour I.
  - A requester whose `d_ack`/`i_last` is high this cycle is masked. This prevents re-grant on a still-high level request.
- I_ISSUE:
  - Issues LINE_WORDS consecutive reads, one per cycle, critical word first.
  - Word k uses index (w+k) mod LINE_WORDS, where w = i_addr word-in-line bits.
  - Address = line base | index<<log2(DATA_W/8).
  - After the last issue, go to I_DRAIN until the last word returns, then IDLE.
- D_READ: one read issue, wait RAM_LAT, then `d_ack` with `d_rdata` = `ram_rdata`, then IDLE.
- D_WRITE: one issue with `ram_we`=1, `ram_be`=`d_be`; `d_ack` the next cycle, then IDLE.
- Return routing uses a RAM_LAT-deep valid/tag delay line (tag = I/D, word index, last). Outputs are derived from it, never from FSM state.
- `i_miss`/`d_req` dropped mid-operation: the operation still completes and strobes fire. The requester ignores them.
- `ram_*` outputs are 0 when not issuing; `ram_be`=0 on reads.

## Timing
- Reset: FSM→IDLE, delay line cleared, priority→I. All outputs are 0 while `rst`, and none pulse from pre-reset issues afterwards.
- Request seen in IDLE at cycle 0 → first RAM issue at cycle 1.
- Load: ack at cycle 1+RAM_LAT; IDLE in that same cycle.
- Store: ack at cycle 2.
- Refill: issues at cycles 1..LINE_WORDS; word k ready at cycle 1+k+RAM_LAT; `i_last` on the last word, IDLE that cycle.
- Minimum gap: next issue one cycle after a completion strobe.
- Throughput: one RAM issue per cycle during a burst; no bubbles inside a burst.

## Structure
- Add to package `constants`:
  - `arb_state_t` enum.
  - `arb_tag_t` struct {valid, is_i, idx, last}.
  - Default LINE_WORDS/RAM_LAT constants.
- Sub-module `ram_lat_pipe`: parameterised RAM_LAT-stage shift register of `arb_tag_t`, async-reset clear.

## Test plan
- Load: d_req, d_addr=0x40, RAM returns 0xDEADBEEF → issue cycle 1, `d_ack` with 0xDEADBEEF at cycle 3 (RAM_LAT=2), single pulse.
- Refill wrap: i_addr=0x108 → `ram_addr` 0x108, 0x10C, 0x100, 0x104 on cycles 1-4; `i_word_idx` 2,3,0,1 on cycles 3-6; `i_last` at cycle 6.
- Contention: i_miss and d_req both high at cycle 0 after reset → I burst first, D read issued the cycle after `i_last`. Repeat both → D first.
- Store: d_we=1, d_be=4'b0011, d_addr=0x20 → cycle 1 `ram_we`=1, `ram_be`=0011; `d_ack` cycle 2; no re-grant while d_req is still high at cycle 2.
- Reset mid-burst: assert rst at cycle 3 of a refill → outputs 0 immediately; after release, no `i_word_ready` until a fresh `i_miss`.
